// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU control path: FSM states, ISA field
// values, write-back source selects and ALU operation codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [3:0] VSEL_MDATA  = 4'b0001;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
  localparam logic [3:0] VSEL_PC     = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b1000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Purely combinational field split of the 16-bit instruction register,
// including sign extension of the two immediate forms.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = sext5(ir[4:0]);
  assign sximm8 = sext8(ir[7:0]);

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus multi-cycle Moore control FSM; every datapath
// control is decoded from the registered state and the registered IR.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [2:0]  opcode,
  output logic [2:0]  state_dbg
);

  logic [15:0] ir_q, ir_d;
  state_e      state_q, state_d;

  logic [1:0] op, sh;
  logic [2:0] rn, rd, rm;

  instr_dec u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  logic is_alu, is_mov_imm, is_mov_reg, is_mvn, is_cmp;
  assign is_alu     = (opcode == OPC_ALU);
  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_mvn     = is_alu && (op == OP_MVN);
  assign is_cmp     = is_alu && (op == OP_CMP);

  // The IR only accepts a new word while idle, so it is stable for the whole instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)               state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)              state_d = S_GET_A;
        else                          state_d = S_WAIT;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    w        = (state_q == S_WAIT);
    readnum  = 3'b000;
    writenum = 3'b000;
    vsel     = VSEL_MDATA;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = (is_alu || is_mov_reg) ? sh : 2'b00;
    ALUop    = is_alu ? op : ALU_ADD;
    case (state_q)
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_SXIMM8;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        asel  = is_mov_reg;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: each instruction is expanded into its expected
// per-edge micro-op trace, compared edge by edge against the DUT.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic        clk, reset_n, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum, opcode, state_dbg;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  cpu_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .opcode(opcode), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // strobe order: write loada loadb loadc loads asel bsel
  localparam logic [6:0] ST_WRITE = 7'b1000000;
  localparam logic [6:0] ST_LOADA = 7'b0100000;
  localparam logic [6:0] ST_LOADB = 7'b0010000;
  localparam logic [6:0] ST_LOADC = 7'b0001000;
  localparam logic [6:0] ST_LOADS = 7'b0000100;
  localparam logic [6:0] ST_ASEL  = 7'b0000010;

  logic [20:0] got_ctrl;
  logic [38:0] got_dec;
  assign got_ctrl = {state_dbg, w, readnum, writenum, vsel,
                     write, loada, loadb, loadc, loads, asel, bsel};
  assign got_dec  = {shift, ALUop, sximm8, sximm5, opcode};

  function automatic logic [20:0] mk(input state_e st, input logic w_, input logic [2:0] rdn,
                                     input logic [2:0] wrn, input logic [3:0] vs,
                                     input logic [6:0] stb);
    return {st, w_, rdn, wrn, vs, stb};
  endfunction

  function automatic logic [38:0] exp_dec(input logic [15:0] wd);
    int i8, i5;
    logic [15:0] s8, s5;
    logic [1:0] shv, aop;
    i8 = int'(wd[7:0]);
    if (i8 > 127) i8 -= 256;
    i5 = int'(wd[4:0]);
    if (i5 > 15) i5 -= 32;
    s8  = i8[15:0];
    s5  = i5[15:0];
    shv = (wd[15:13] == 3'b101 || wd[15:11] == 5'b11000) ? wd[4:3] : 2'b00;
    aop = (wd[15:13] == 3'b101) ? wd[12:11] : 2'b00;
    return {shv, aop, s8, s5, wd[15:13]};
  endfunction

  logic [20:0] exp_q[$];

  // Expected control vector after each clock edge, starting at the s-sampling edge.
  task automatic push_model(input logic [15:0] wd);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    logic mov_reg;
    opc = wd[15:13]; op = wd[12:11]; rn = wd[10:8]; rd = wd[7:5]; rm = wd[2:0];
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    exp_q.push_back(mk(S_DECODE, 1'b0, 3'd0, 3'd0, 4'b0001, 7'd0));
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(mk(S_WRITE_IMM, 1'b0, 3'd0, rn, 4'b0010, ST_WRITE));
    end else if (mov_reg || (opc == 3'b101 && op == 2'b11)) begin
      exp_q.push_back(mk(S_GET_B, 1'b0, rm, 3'd0, 4'b0001, ST_LOADB));
      exp_q.push_back(mk(S_ALU, 1'b0, 3'd0, 3'd0, 4'b0001, ST_LOADC | (mov_reg ? ST_ASEL : 7'd0)));
      exp_q.push_back(mk(S_WRITE_REG, 1'b0, 3'd0, rd, 4'b1000, ST_WRITE));
    end else if (opc == 3'b101) begin
      exp_q.push_back(mk(S_GET_A, 1'b0, rn, 3'd0, 4'b0001, ST_LOADA));
      exp_q.push_back(mk(S_GET_B, 1'b0, rm, 3'd0, 4'b0001, ST_LOADB));
      if (op == 2'b01) begin
        exp_q.push_back(mk(S_ALU, 1'b0, 3'd0, 3'd0, 4'b0001, ST_LOADS));
      end else begin
        exp_q.push_back(mk(S_ALU, 1'b0, 3'd0, 3'd0, 4'b0001, ST_LOADC));
        exp_q.push_back(mk(S_WRITE_REG, 1'b0, 3'd0, rd, 4'b1000, ST_WRITE));
      end
    end
    exp_q.push_back(mk(S_WAIT, 1'b1, 3'd0, 3'd0, 4'b0001, 7'd0));
  endtask

  // driver: load + start an instruction, then walk the expected trace;
  // while busy, load/s/in are randomized and must have no effect.
  task automatic run_instr(input logic [15:0] wd, input bit hold_s);
    int first_len, total, n;
    logic [38:0] ed;
    logic [20:0] e;
    exp_q.delete();
    push_model(wd);
    first_len = exp_q.size();
    if (hold_s) push_model(wd);
    total = exp_q.size();
    ed = exp_dec(wd);
    @(negedge clk);
    in = wd; load = 1'b1; s = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      e = exp_q.pop_front();
      check_val($sformatf("ctrl %h edge%0d", wd, n), got_ctrl, e);
      check_val($sformatf("dec %h edge%0d", wd, n), got_dec, ed);
      if (hold_s) begin
        load = 1'b0;
        s    = (n <= first_len);
      end else if (n < total) begin
        load = 1'($urandom_range(0, 1));
        in   = 16'($urandom);
        s    = 1'($urandom_range(0, 1));
      end else begin
        load = 1'b0;
        s    = 1'b0;
      end
    end
  endtask

  task automatic reset_mid(input logic [15:0] wd, input int k, input logic [20:0] pre_exp);
    @(negedge clk);
    in = wd; load = 1'b1; s = 1'b1;
    repeat (k) begin
      @(negedge clk);
      load = 1'b0; s = 1'b0;
    end
    check_val($sformatf("pre_rst %h", wd), got_ctrl, pre_exp);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_async_ctrl", got_ctrl, mk(S_WAIT, 1'b1, 3'd0, 3'd0, 4'b0001, 7'd0));
    check_val("rst_async_dec", got_dec, 39'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ctrl", got_ctrl, mk(S_WAIT, 1'b1, 3'd0, 3'd0, 4'b0001, 7'd0));
  endtask

  initial begin
    logic [15:0] wr;
    int k;
    reset_n = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", got_ctrl, mk(S_WAIT, 1'b1, 3'd0, 3'd0, 4'b0001, 7'd0));
    check_val("reset_dec", got_dec, 39'd0);
    reset_n = 1'b1;

    // load without start: IR updates, FSM stays idle
    @(negedge clk);
    in = 16'hD3FB; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_val("load_only_ctrl", got_ctrl, mk(S_WAIT, 1'b1, 3'd0, 3'd0, 4'b0001, 7'd0));
    check_val("load_only_dec", got_dec, exp_dec(16'hD3FB));
    check_val("load_only_sximm8", sximm8, 16'hFFFB);

    run_instr(16'hD3FB, 1'b0);  // MOV R3,#-5
    run_instr(16'hA148, 1'b0);  // ADD R2,R1,R0,LSL#1
    run_instr(16'hAC05, 1'b0);  // CMP R4,R5
    run_instr(16'hC0FE, 1'b0);  // MOV R7,R6,ASR
    run_instr(16'hB8E1, 1'b0);  // MVN R7,R1
    run_instr(16'hB2A3, 1'b0);  // AND R5,R2,R3
    run_instr(16'hE000, 1'b0);  // illegal
    run_instr(16'hD3FB, 1'b1);  // s held high relaunches

    reset_mid(16'hA148, 3, mk(S_GET_B, 1'b0, 3'd0, 3'd0, 4'b0001, ST_LOADB));
    reset_mid(16'hD3FB, 2, mk(S_WRITE_IMM, 1'b0, 3'd0, 3'd3, 4'b0010, ST_WRITE));

    repeat (40) begin
      wr = 16'($urandom);
      k = $urandom_range(0, 6);
      case (k)
        0: wr[15:11] = 5'b11010;
        1: wr[15:11] = 5'b11000;
        2: wr[15:11] = 5'b10100;
        3: wr[15:11] = 5'b10101;
        4: wr[15:11] = 5'b10110;
        5: wr[15:11] = 5'b10111;
        default: ;
      endcase
      run_instr(wr, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
